// File: rtl/apb_pkg.sv
// Shared types and widths for the APB register-bank completer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W      = 32;
  localparam int unsigned APB_DATA_W      = 32;
  localparam int unsigned APB_SEL_W       = 3;
  localparam int unsigned APB_REGION_BITS = 26;
  localparam int unsigned APB_WAIT_W      = 4;
  localparam int unsigned APB_CNT_W       = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

  // Transfer attributes latched in the setup phase.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic                  oor;
  } apb_req_t;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32-bit register storage: async-reset clear, one write port, one combinational read port.
module apb_regfile
  import apb_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer behind the AHB-to-APB bridge: register bank with wait states,
// out-of-range error response, sticky protocol-violation flag and transfer counters.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned SEL_IDX     = 0,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [APB_SEL_W-1:0]  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic                  proto_err,
  output logic [APB_CNT_W-1:0]  wr_cnt,
  output logic [APB_CNT_W-1:0]  rd_cnt
);

  localparam int unsigned                 IDX_W        = $clog2(DEPTH);
  localparam logic [APB_REGION_BITS-1:0]  REGION_LIMIT = APB_REGION_BITS'(DEPTH * 4);
  localparam logic [APB_WAIT_W-1:0]       WAIT_LOAD    = APB_WAIT_W'(WAIT_STATES);

  apb_slv_state_t        state_q, state_d;
  logic [APB_WAIT_W-1:0] wait_q, wait_d;
  apb_req_t              req_q, req_d;
  logic                  proto_q, proto_set_c;
  logic [APB_CNT_W-1:0]  wr_cnt_q, rd_cnt_q;

  logic                  sel_c, oor_c, match_c, done_c, reg_we_c;
  logic [IDX_W-1:0]      idx_c;
  logic [APB_DATA_W-1:0] reg_rdata_c;
  logic [APB_SEL_W-1:0]  unused_pselx;

  assign sel_c        = Pselx[SEL_IDX];
  assign unused_pselx = Pselx;
  assign oor_c        = (Paddr[APB_REGION_BITS-1:0] >= REGION_LIMIT);
  assign idx_c        = req_q.addr[2 +: IDX_W];
  // Access phase is legal only while select, enable, address and direction hold steady.
  assign match_c      = sel_c & Penable & (Paddr == req_q.addr) & (Pwrite == req_q.write);

  // State register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= IDLE;
      wait_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    req_d       = req_q;
    proto_set_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_c && !Penable) begin
          req_d   = '{addr: Paddr, write: Pwrite, wdata: Pwdata, oor: oor_c};
          wait_d  = WAIT_LOAD;
          state_d = ACCESS;
        end else if (sel_c && Penable) begin
          proto_set_c = 1'b1;
        end
      end
      ACCESS: begin
        if (!match_c) begin
          proto_set_c = 1'b1;
          state_d     = IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - APB_WAIT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done_c   = (state_q == ACCESS) && (wait_q == '0) && sel_c && Penable;
    Pready   = done_c;
    Pslverr  = done_c & req_q.oor;
    reg_we_c = done_c & req_q.write & ~req_q.oor;
    Prdata   = (done_c && !req_q.write && !req_q.oor) ? reg_rdata_c : '0;
  end

  // Sticky violation flag and completed-transfer counters
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      proto_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (proto_set_c) begin
        proto_q <= 1'b1;
      end
      if (done_c && !req_q.oor) begin
        if (req_q.write) begin
          wr_cnt_q <= wr_cnt_q + APB_CNT_W'(1);
        end else begin
          rd_cnt_q <= rd_cnt_q + APB_CNT_W'(1);
        end
      end
    end
  end

  assign proto_err = proto_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;

  apb_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (Hclk),
    .rst_n   (Hresetn),
    .we_i    (reg_we_c),
    .waddr_i (idx_c),
    .wdata_i (req_q.wdata),
    .raddr_i (idx_c),
    .rdata_o (reg_rdata_c)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized self-checking bench: two register banks (0 and 3 wait states) against a transaction-level model.
module tb_apb_slave_regbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pselx     [2];
  logic        penable   [2];
  logic        pwrite    [2];
  logic [31:0] paddr     [2];
  logic [31:0] pwdata    [2];
  logic [31:0] prdata    [2];
  logic        pready    [2];
  logic        pslverr   [2];
  logic        proto_err [2];
  logic [15:0] wr_cnt    [2];
  logic [15:0] rd_cnt    [2];

  logic [31:0] mem_m   [2][16];
  int unsigned wrc_m   [2];
  int unsigned rdc_m   [2];
  bit          proto_m [2];
  int          wait_m  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.SEL_IDX(0), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(pselx[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
    .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Prdata(prdata[0]), .Pready(pready[0]),
    .Pslverr(pslverr[0]), .proto_err(proto_err[0]), .wr_cnt(wr_cnt[0]), .rd_cnt(rd_cnt[0])
  );

  apb_slave_regbank #(.SEL_IDX(0), .DEPTH(16), .WAIT_STATES(3)) u_dut1 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(pselx[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
    .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Prdata(prdata[1]), .Pready(pready[1]),
    .Pslverr(pslverr[1]), .proto_err(proto_err[1]), .wr_cnt(wr_cnt[1]), .rd_cnt(rd_cnt[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
      wrc_m[d]   = 0;
      rdc_m[d]   = 0;
      proto_m[d] = 1'b0;
    end
  endtask

  task automatic bus_idle(input int d);
    pselx[d]   = 3'b000;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b0;
    paddr[d]   = 32'h0;
    pwdata[d]  = 32'h0;
  endtask

  task automatic check_status(input int d, input string tag);
    check_eq({tag, "_wr_cnt"}, 32'(wr_cnt[d]), 32'(wrc_m[d][15:0]));
    check_eq({tag, "_rd_cnt"}, 32'(rd_cnt[d]), 32'(rdc_m[d][15:0]));
    check_eq({tag, "_proto"},  32'(proto_err[d]), 32'(proto_m[d]));
  endtask

  // One legal transfer; entered between clock edges, leaves just after the completing edge.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int          waits;
    bit          oor;
    int          idx;
    logic [31:0] exp_rd;
    oor    = (addr[25:0] >= 26'd64);
    idx    = int'(addr[5:2]);
    exp_rd = (!wr && !oor) ? mem_m[d][idx] : 32'h0;
    pselx[d] = 3'b001; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    #1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      @(posedge clk); #2;
      waits++;
    end
    check_eq("wait_states", 32'(waits), 32'(wait_m[d]));
    check_eq("pslverr", 32'(pslverr[d]), 32'(oor));
    check_eq("prdata", prdata[d], exp_rd);
    @(posedge clk); #1;
    bus_idle(d);
    if (!oor) begin
      if (wr) begin
        mem_m[d][idx] = wdata;
        wrc_m[d]++;
      end else begin
        rdc_m[d]++;
      end
    end
    #1;
    check_status(d, "xfer");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_m[0] = 0;
    wait_m[1] = 3;
    model_reset();
    bus_idle(0);
    bus_idle(1);
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_prdata", prdata[d], 32'h0);
      check_eq("rst_pready", 32'(pready[d]), 32'h0);
      check_eq("rst_pslverr", 32'(pslverr[d]), 32'h0);
      check_status(d, "rst");
    end
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    // Wait-state bank: cold read of register 0
    apb_xfer(1, 1'b0, 32'h8000_0000, 32'h0);

    // Write then read
    apb_xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
    apb_xfer(0, 1'b0, 32'h8000_0004, 32'h0);

    // Out-of-range write, then confirm nothing landed
    apb_xfer(0, 1'b1, 32'h8000_0040, 32'hCAFE_F00D);
    apb_xfer(0, 1'b0, 32'h8000_0000, 32'h0);
    apb_xfer(1, 1'b1, 32'h8000_0044, 32'h1111_2222);

    // Back-to-back write/read
    apb_xfer(0, 1'b1, 32'h8000_0008, 32'h0000_1234);
    apb_xfer(0, 1'b0, 32'h8000_0008, 32'h0);

    // Another peripheral's select must be ignored
    pselx[0] = 3'b010; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h8000_0010; pwdata[0] = 32'h7777_7777;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #1 check_eq("foreign_sel_pready", 32'(pready[0]), 32'h0);
    @(posedge clk); #2;
    check_eq("foreign_sel_pready2", 32'(pready[0]), 32'h0);
    bus_idle(0);
    #1 check_status(0, "foreign_sel");
    apb_xfer(0, 1'b0, 32'h8000_0010, 32'h0);

    // Enable asserted with select while idle
    pselx[0] = 3'b001; penable[0] = 1'b1; paddr[0] = 32'h8000_0000;
    @(posedge clk); #1;
    bus_idle(0);
    proto_m[0] = 1'b1;
    #1 check_status(0, "idle_enable");
    check_eq("dut1_proto_clean", 32'(proto_err[1]), 32'(proto_m[1]));

    // Select dropped mid-access on the wait-state bank
    pselx[1] = 3'b001; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8000_000C; pwdata[1] = 32'hBAD0_0003;
    @(posedge clk); #1;
    pselx[1] = 3'b000; penable[1] = 1'b1;
    #1 check_eq("psel_drop_pready", 32'(pready[1]), 32'h0);
    @(posedge clk); #1;
    bus_idle(1);
    proto_m[1] = 1'b1;
    #1 check_status(1, "psel_drop");
    apb_xfer(1, 1'b0, 32'h8000_000C, 32'h0);

    // Randomized traffic on both banks
    for (int n = 0; n < 120; n++) begin
      int          d;
      bit          wr;
      logic [25:0] off;
      d  = int'($urandom_range(1, 0));
      wr = 1'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) off = 26'($urandom_range(32'h03FF_FFFF, 64));
      else                           off = 26'($urandom_range(63, 0));
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
      end
      apb_xfer(d, wr, 32'h8000_0000 | 32'(off), $urandom());
    end

    // Asynchronous reset in the middle of a write access
    apb_xfer(0, 1'b1, 32'h8000_0008, 32'h2222_2222);
    pselx[0] = 3'b001; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h8000_0008; pwdata[0] = 32'h5555_AAAA;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #1 check_eq("pre_reset_pready", 32'(pready[0]), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("reset_pready", 32'(pready[0]), 32'h0);
    check_status(0, "mid_reset");
    check_status(1, "mid_reset");
    bus_idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 32'h8000_0008, 32'h0);
    apb_xfer(1, 1'b0, 32'h8000_0004, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
